// File: rtl/reg_transfer_unit_pkg.sv
// Shared definitions for the register transfer unit.
// Holds the sequencer state encoding, register index width, register count,
// default data width and the write-port request record used by the bank.
package reg_transfer_unit_pkg;

    localparam int REG_IDX_W = 3;
    localparam int NUM_REGS  = 8;
    localparam int DEF_WIDTH = 16;
    localparam int CNT_W     = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2
    } xfer_state_t;

    // Write-port request; data travels alongside because its width is a
    // module parameter.
    typedef struct packed {
        logic                 we;
        logic [REG_IDX_W-1:0] addr;
    } wr_req_t;

endpackage

// File: rtl/reg_transfer_unit_reg_bank_8.sv
// reg_bank_8: eight WIDTH-bit registers with two write ports.
// Ports:
//   clk, rst            - rising-edge clock, synchronous active-high reset
//   xfer_req/xfer_data  - write port from the transfer sequencer
//   ext_req/ext_data    - external direct-load write port
//   regs                - all register contents, packed, index 0..7
// When both ports target the same register in one cycle the transfer write
// is kept; writes to different registers both land.
module reg_bank_8
    import reg_transfer_unit_pkg::*;
#(
    parameter int               WIDTH     = DEF_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  wr_req_t                            xfer_req,
    input  logic [WIDTH-1:0]                   xfer_data,
    input  wr_req_t                            ext_req,
    input  logic [WIDTH-1:0]                   ext_data,
    output logic [NUM_REGS-1:0][WIDTH-1:0]     regs
);

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (xfer_req.we && xfer_req.addr == REG_IDX_W'(i))
                    regs[i] <= xfer_data;
                else if (ext_req.we && ext_req.addr == REG_IDX_W'(i))
                    regs[i] <= ext_data;
            end
        end
    end

endmodule

// File: rtl/reg_transfer_unit.sv
// reg_transfer_unit: eight-entry register bank plus a MOV Rd,Rs sequencer
// that drives an external 8:1 mux (r0..r7 -> in0..in7, sel -> select) and
// captures the mux output returned on bus_in.
// Ports:
//   clk, rst                     - clock, synchronous active-high reset
//   ext_load/ext_addr/ext_data   - direct register load, any state
//   cmd_valid/cmd_ready          - transfer handshake
//   cmd_src/cmd_dst              - source / destination register index
//   bus_in                       - mux output fed back
//   sel                          - mux select, holds last accepted source
//   done                         - one-cycle pulse after the destination write
//   r0..r7                       - register contents
module reg_transfer_unit
    import reg_transfer_unit_pkg::*;
#(
    parameter int               WIDTH         = DEF_WIDTH,
    parameter int               SETTLE_CYCLES = 1,
    parameter logic [WIDTH-1:0] RESET_VAL     = '0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ext_load,
    input  logic [REG_IDX_W-1:0] ext_addr,
    input  logic [WIDTH-1:0]     ext_data,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [REG_IDX_W-1:0] cmd_src,
    input  logic [REG_IDX_W-1:0] cmd_dst,
    input  logic [WIDTH-1:0]     bus_in,
    output logic [REG_IDX_W-1:0] sel,
    output logic                 done,
    output logic [WIDTH-1:0]     r0,
    output logic [WIDTH-1:0]     r1,
    output logic [WIDTH-1:0]     r2,
    output logic [WIDTH-1:0]     r3,
    output logic [WIDTH-1:0]     r4,
    output logic [WIDTH-1:0]     r5,
    output logic [WIDTH-1:0]     r6,
    output logic [WIDTH-1:0]     r7
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);

    xfer_state_t                   state, state_nx;
    logic [CNT_W-1:0]              cnt;
    logic [REG_IDX_W-1:0]          src_q, dst_q;
    wr_req_t                       xfer_req, ext_req;
    logic [NUM_REGS-1:0][WIDTH-1:0] regs;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            src_q <= '0;
            dst_q <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_nx;
            // done marks the cycle following the destination write
            done  <= (state == CAPTURE);
            case (state)
                IDLE: if (cmd_valid) begin
                    src_q <= cmd_src;
                    dst_q <= cmd_dst;
                    cnt   <= CNT_INIT;
                end
                SETTLE: if (cnt != '0) cnt <= cnt - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_nx  = state;
        cmd_ready = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nx = SETTLE;
            end
            SETTLE:  if (cnt == '0) state_nx = CAPTURE;
            CAPTURE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // sel is the latched source, so it only moves on command acceptance
    assign sel = src_q;

    always_comb begin
        xfer_req      = '0;
        xfer_req.we   = (state == CAPTURE);
        xfer_req.addr = dst_q;
        ext_req       = '0;
        ext_req.we    = ext_load;
        ext_req.addr  = ext_addr;
    end

    reg_bank_8 #(
        .WIDTH     (WIDTH),
        .RESET_VAL (RESET_VAL)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .xfer_req  (xfer_req),
        .xfer_data (bus_in),
        .ext_req   (ext_req),
        .ext_data  (ext_data),
        .regs      (regs)
    );

    assign r0 = regs[0];
    assign r1 = regs[1];
    assign r2 = regs[2];
    assign r3 = regs[3];
    assign r4 = regs[4];
    assign r5 = regs[5];
    assign r6 = regs[6];
    assign r7 = regs[7];

endmodule

// File: tb/tb_reg_transfer_unit.sv
// Bench for reg_transfer_unit: two instances (SETTLE_CYCLES 1 and 3), each
// wired to a behavioural 8:1 mux, checked against a register model and a
// scoreboard of pending transfer results.
module tb_reg_transfer_unit;

    logic        clk = 1'b0;
    logic        rst [2];
    logic        ext_load [2];
    logic [2:0]  ext_addr [2];
    logic [15:0] ext_data [2];
    logic        cmd_valid [2];
    logic        cmd_ready [2];
    logic [2:0]  cmd_src [2];
    logic [2:0]  cmd_dst [2];
    logic [15:0] bus_in [2];
    logic [2:0]  sel [2];
    logic        done [2];
    logic [15:0] rr [2][8];

    always #5 clk = ~clk;

    for (genvar u = 0; u < 2; u++) begin : g_dut
        reg_transfer_unit #(.WIDTH(16), .SETTLE_CYCLES(u == 0 ? 1 : 3), .RESET_VAL(16'h0)) dut (
            .clk(clk), .rst(rst[u]),
            .ext_load(ext_load[u]), .ext_addr(ext_addr[u]), .ext_data(ext_data[u]),
            .cmd_valid(cmd_valid[u]), .cmd_ready(cmd_ready[u]),
            .cmd_src(cmd_src[u]), .cmd_dst(cmd_dst[u]),
            .bus_in(bus_in[u]), .sel(sel[u]), .done(done[u]),
            .r0(rr[u][0]), .r1(rr[u][1]), .r2(rr[u][2]), .r3(rr[u][3]),
            .r4(rr[u][4]), .r5(rr[u][5]), .r6(rr[u][6]), .r7(rr[u][7])
        );
        // external sixteen_bit_8_to_1_MUX behaviour
        assign bus_in[u] = rr[u][sel[u]];
    end

    typedef struct { logic [2:0] addr; logic [15:0] data; } ld_vec_t;
    typedef struct { int u; logic [2:0] src; logic [2:0] dst; logic [15:0] val; } sb_t;

    ld_vec_t     ld_tbl [8];
    sb_t         sbq [$];
    logic [15:0] m [2][8];
    int          pass_cnt = 0;
    int          total    = 0;

    function automatic int st(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic chk_model(input int u);
        for (int i = 0; i < 8; i++) chk($sformatf("u%0d_r%0d_model", u, i), rr[u][i], m[u][i]);
    endtask

    task automatic start_cmd(input int u, input logic [2:0] s, input logic [2:0] d);
        cmd_valid[u] = 1'b1; cmd_src[u] = s; cmd_dst[u] = d;
        tick();
        cmd_valid[u] = 1'b0;
        chk("sel_on_accept", sel[u], s);
        chk("ready_after_accept", cmd_ready[u], 1'b0);
        sbq.push_back('{u, s, d, m[u][s]});
    endtask

    // Waits (bounded) for done; optionally fires an ext_load in the CAPTURE cycle.
    task automatic finish_cmd(input int u, input bit ext_en, input logic [2:0] ea, input logic [15:0] ed);
        int  n = 0;
        int  low = 0;
        bit  got = 1'b0;
        sb_t e;
        while (n < 20 && !got) begin
            if (!cmd_ready[u]) low++;
            if (ext_en && n == st(u)) begin
                ext_load[u] = 1'b1; ext_addr[u] = ea; ext_data[u] = ed;
            end
            tick();
            n++;
            ext_load[u] = 1'b0;
            got = done[u];
        end
        chk("done_seen", got, 1'b1);
        if (got && sbq.size() > 0) begin
            e = sbq.pop_front();
            chk("latency", n, st(u) + 1);
            chk("ready_low_cycles", low, st(u) + 1);
            chk("ready_at_done", cmd_ready[u], 1'b1);
            chk("sel_held", sel[u], e.src);
            if (ext_en) m[u][ea] = ed;
            m[u][e.dst] = e.val;
            chk("xfer_dst", rr[u][e.dst], e.val);
            chk_model(u);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 8; i++) ld_tbl[i] = '{3'(i), 16'(16'h1111 * (i + 1))};
        for (int u = 0; u < 2; u++) begin
            rst[u] = 1'b1; ext_load[u] = 1'b0; ext_addr[u] = '0; ext_data[u] = '0;
            cmd_valid[u] = 1'b0; cmd_src[u] = '0; cmd_dst[u] = '0;
            for (int i = 0; i < 8; i++) m[u][i] = '0;
        end
        tick(); tick();
        rst[0] = 1'b0; rst[1] = 1'b0;

        // reset state
        for (int u = 0; u < 2; u++) begin
            chk("rst_ready", cmd_ready[u], 1'b1);
            chk("rst_sel", sel[u], 3'd0);
            chk("rst_done", done[u], 1'b0);
            chk_model(u);
        end

        // table-driven external loads on both units, then readback
        for (int i = 0; i < 8; i++) begin
            for (int u = 0; u < 2; u++) begin
                ext_load[u] = 1'b1; ext_addr[u] = ld_tbl[i].addr; ext_data[u] = ld_tbl[i].data;
            end
            tick();
        end
        ext_load[0] = 1'b0; ext_load[1] = 1'b0;
        for (int u = 0; u < 2; u++) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("ld_u%0d_r%0d", u, ld_tbl[i].addr), rr[u][ld_tbl[i].addr], ld_tbl[i].data);
                m[u][ld_tbl[i].addr] = ld_tbl[i].data;
            end
            chk("ld_sel", sel[u], 3'd0);
            chk("ld_ready", cmd_ready[u], 1'b1);
        end

        // unit 0, SETTLE_CYCLES=1: MOV r1,r6
        start_cmd(0, 3'd6, 3'd1);
        finish_cmd(0, 1'b0, 3'd0, 16'h0);
        chk("mov61_r1", rr[0][1], 16'h7777);
        chk("mov61_r6", rr[0][6], 16'h7777);
        tick();
        chk("done_one_cycle", done[0], 1'b0);

        // src == dst
        start_cmd(0, 3'd4, 3'd4);
        finish_cmd(0, 1'b0, 3'd0, 16'h0);
        chk("self_r4", rr[0][4], 16'h5555);

        // ext_load to dst during CAPTURE: transfer wins
        start_cmd(0, 3'd2, 3'd5);
        finish_cmd(0, 1'b1, 3'd5, 16'hBEEF);
        chk("coll_same_r5", rr[0][5], 16'h3333);
        // ext_load to another register during CAPTURE: both land
        start_cmd(0, 3'd2, 3'd5);
        finish_cmd(0, 1'b1, 3'd4, 16'hBEEF);
        chk("coll_diff_r4", rr[0][4], 16'hBEEF);
        chk("coll_diff_r5", rr[0][5], 16'h3333);

        // unit 1, SETTLE_CYCLES=3: MOV r7,r0 with cmd_valid held through busy
        start_cmd(1, 3'd0, 3'd7);
        cmd_valid[1] = 1'b1; cmd_src[1] = 3'd3; cmd_dst[1] = 3'd6;
        finish_cmd(1, 1'b0, 3'd0, 16'h0);
        chk("mov07_r7", rr[1][7], 16'h1111);
        tick();
        cmd_valid[1] = 1'b0;
        chk("held_done_low", done[1], 1'b0);
        chk("held_sel", sel[1], 3'd3);
        sbq.push_back('{1, 3'd3, 3'd6, m[1][3]});
        finish_cmd(1, 1'b0, 3'd0, 16'h0);
        chk("held_r6", rr[1][6], 16'h4444);

        // all 64 src/dst pairs on unit 0
        for (int s = 0; s < 8; s++)
            for (int d = 0; d < 8; d++) begin
                start_cmd(0, 3'(s), 3'(d));
                finish_cmd(0, 1'b0, 3'd0, 16'h0);
            end
        tick();
        chk_model(0);

        // reset during SETTLE on unit 1 aborts the transfer
        cmd_valid[1] = 1'b1; cmd_src[1] = 3'd3; cmd_dst[1] = 3'd0;
        tick();
        cmd_valid[1] = 1'b0;
        tick();
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        for (int i = 0; i < 8; i++) m[1][i] = '0;
        chk_model(1);
        chk("abort_sel", sel[1], 3'd0);
        chk("abort_done", done[1], 1'b0);
        chk("abort_ready", cmd_ready[1], 1'b1);
        ext_load[1] = 1'b1; ext_addr[1] = 3'd3; ext_data[1] = 16'hABCD;
        tick();
        ext_load[1] = 1'b0;
        m[1][3] = 16'hABCD;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_no_done", done[1], 1'b0);
        end
        chk("abort_r0", rr[1][0], 16'h0);
        chk_model(1);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule

// File: doc/reg_transfer_unit.md
Name: reg_transfer_unit

Overview:
- Eight-entry register bank with a register-to-register transfer sequencer; sits directly upstream of sixteen_bit_8_to_1_MUX.
- r0..r7 drive the mux inputs in0..in7, sel drives the mux select, and the mux output out1 returns on bus_in.
- Executes MOV Rd,Rs: drives sel=Rs, waits for the bus to settle, then loads bus_in into Rd.
- Also supports direct external register loads.

Parameters:
WIDTH, 16, register/bus data width
SETTLE_CYCLES, 1, cycles sel is held before capture (legal 1..15)
RESET_VAL, 0, reset value of every register

Ports:
clk  in  1  single rising-edge clock
rst  in  1  synchronous, active-high reset
ext_load  in  1  external write strobe
ext_addr  in  3  external write register index
ext_data  in  WIDTH  external write data
cmd_valid  in  1  transfer request
cmd_ready  out  1  unit can accept a transfer
cmd_src  in  3  source register index
cmd_dst  in  3  destination register index
bus_in  in  WIDTH  mux out1 fed back
sel  out  3  mux select
done  out  1  one-cycle pulse, transfer complete
r0..r7  out  WIDTH each  register contents to mux in0..in7

Behaviour:
- Reset (synchronous): r0..r7=RESET_VAL, sel=0, done=0, state=IDLE, settle counter=0, latched src/dst=0. Reset mid-transfer aborts it with no register write.
- FSM states: IDLE, SETTLE, CAPTURE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid at an edge: latch src/dst, set sel=src, load counter=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - cmd_ready=0; sel held at src.
  - If counter==0 go to CAPTURE, else decrement.
- CAPTURE:
  - cmd_ready=0; sel held.
  - At the edge: r[dst]<=bus_in, done<=1 for the following cycle, go to IDLE.
- Latency: command accepted at edge T → sel valid after T → r[dst] updated at edge T+SETTLE_CYCLES+1 → done high during the cycle after that edge.
- sel retains the last source in IDLE; it changes only on command acceptance.
- cmd_valid is ignored while not IDLE. A command presented on the same edge that done rises is not accepted, because state is still CAPTURE.
- ext_load is accepted in any state: r[ext_addr]<=ext_data at the edge.
- Simultaneous ext_load and CAPTURE write:
  - Same register: the transfer write wins.
  - Different registers: both written.
- ext_load to the current src during SETTLE changes bus_in. The captured value is whatever bus_in holds at the CAPTURE edge; this is not an error.
- src==dst is legal: the register reloads its own value.
- No arithmetic; all writes are full WIDTH. Counter width is 4 bits.

Decomposition:
- Shared package:
  - state encoding constants (IDLE=2'd0, SETTLE=2'd1, CAPTURE=2'd2)
  - register index width (3)
  - default WIDTH
- One natural sub-module: reg_bank_8 holds the eight registers, the write-port priority logic (transfer over external) and the r0..r7 outputs. The FSM and counter stay in the top module.
- The 8:1 mux is not instantiated inside this block. The bench connects the two externally.

Test Plan:
- Reset, then ext_load writes 16'h1111..16'h8888 to r0..r7 on consecutive cycles → r0..r7 read back 16'h1111..16'h8888; sel=0; cmd_ready=1.
- With the mux connected, SETTLE_CYCLES=1, cmd src=6 dst=1 → sel=6 from the cycle after acceptance; r1=16'h7777 two edges after acceptance; done pulses for exactly 1 cycle; r6 unchanged at 16'h7777.
- SETTLE_CYCLES=3, src=0 dst=7 → cmd_ready low for 4 cycles; r7=16'h1111 at edge T+4; cmd_valid held high during busy is not accepted until IDLE returns.
- During CAPTURE of src=2 dst=5, assert ext_load addr=5 data=16'hBEEF → r5=16'h3333 (transfer wins). Repeat with ext_addr=4 → r4=16'hBEEF and r5=16'h3333.
- Assert rst during SETTLE of src=3 dst=0 → next cycle all registers 0, sel=0, done=0, cmd_ready=1; no write to r0 occurs.
- Command src=4 dst=4 → r4 stays 16'h5555; done pulses; loop all src/dst pairs (64) against a reference model → final register contents match.
